to_bcd: RTL and testbench

TO_BCD -- requirements
Module: to_bcd

---
 rtl/to_bcd_if.sv | 26 ++
 rtl/to_bcd.sv | 94 +++++++++
 tb/tb_to_bcd.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/to_bcd_if.sv
// Request/result bundle for the to_bcd converter.
// The master issues start/bin_d_in; the slave returns bcd_d_out, busy and done.
`timescale 1ns/1ps
interface to_bcd_if;
    logic        start;
    logic [14:0] bin_d_in;
    logic [18:0] bcd_d_out;
    logic        busy;
    logic        done;

    modport master (
        output start,
        output bin_d_in,
        input  bcd_d_out,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  bin_d_in,
        output bcd_d_out,
        output busy,
        output done
    );
endinterface

// File: rtl/to_bcd.sv
// Sequential 15-bit binary to 5-digit BCD converter (double dabble, MSB first).
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start; result register holds the last value
// ST_SHIFT | 15 cycles of add-3 adjust followed by a 1-bit left shift
// ST_DONE  | one cycle: result register and done pulse loaded on its edge
`timescale 1ns/1ps
module to_bcd (
    input  logic     clk,
    input  logic     rst,
    to_bcd_if.slave  bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [3:0] N_BITS = 4'd15;

    logic [1:0]  state_q, state_d;
    logic [14:0] bin_q,   bin_d;
    logic [18:0] scr_q,   scr_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [18:0] bcd_q,   bcd_d;
    logic        done_q,  done_d;
    logic [18:0] scr_adj;

    // The top field never reaches 5 for a 15-bit operand, so only the four
    // lower digits need the add-3 correction.
    always_comb begin
        scr_adj = scr_q;
        for (int i = 0; i < 4; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) begin
                scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    bin_d   = bus.bin_d_in;
                    scr_d   = '0;
                    cnt_d   = N_BITS;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {scr_d, bin_d} = {scr_adj[17:0], bin_q, 1'b0};
                cnt_d          = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bcd_d   = scr_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
        end
    end

    assign bus.bcd_d_out = bcd_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = done_q;
endmodule

// File: tb/tb_to_bcd.sv
// Scoreboard bench for to_bcd: a decimal-arithmetic reference predicts each
// result and the edge on which its done pulse must appear.
`timescale 1ns/1ps
module tb_to_bcd;
    logic clk = 1'b0;
    logic rst;

    to_bcd_if bif ();

    to_bcd dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [18:0] val;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          cyc       = 0;
    int          mdl_left  = 0;
    logic        mdl_busy  = 1'b0;
    logic [18:0] mdl_out   = '0;
    logic        chk_en    = 1'b0;
    int          n_chk     = 0;
    int          n_pass    = 0;

    function automatic logic [18:0] ref_bcd(input int v);
        return {3'(v / 10000), 4'((v / 1000) % 10), 4'((v / 100) % 10),
                4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference: a conversion accepted on edge c occupies the block until edge
    // c+16, on which the result and the done pulse appear (17 edges inclusive).
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            sb.delete();
            mdl_left = 0;
            mdl_out  = '0;
            chk_en   = 1'b1;
        end else if (mdl_left == 0 && bif.start) begin
            sb.push_back('{val: ref_bcd(int'(bif.bin_d_in)), due: cyc + 16});
            mdl_left = 16;
        end else if (mdl_left > 0) begin
            mdl_left--;
        end
        mdl_busy = (mdl_left > 0);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                check("done_pulse", 32'(bif.done), 32'd1);
                check("bcd_result", 32'(bif.bcd_d_out), 32'(sb[0].val));
                mdl_out = sb[0].val;
                void'(sb.pop_front());
            end else begin
                check("no_done", 32'(bif.done), 32'd0);
            end
            check("busy", 32'(bif.busy), 32'(mdl_busy));
            check("bcd_hold", 32'(bif.bcd_d_out), 32'(mdl_out));
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((mdl_left != 0 || sb.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            n_chk++;
            $display("FAIL idle_timeout at cycle %0d: got busy expected idle", cyc);
        end
    endtask

    task automatic run_one(input int v);
        @(negedge clk);
        bif.start    = 1'b1;
        bif.bin_d_in = 15'(v);
        @(negedge clk);
        bif.start    = 1'b0;
        bif.bin_d_in = 15'($urandom_range(0, 32767));
        wait_idle();
    endtask

    int directed[9] = '{0, 9, 45, 123, 128, 999, 1234, 9999, 32767};

    initial begin
        rst          = 1'b1;
        bif.start    = 1'b0;
        bif.bin_d_in = '0;
        repeat (3) @(negedge clk);
        check("reset_bcd", 32'(bif.bcd_d_out), 32'd0);
        check("reset_busy", 32'(bif.busy), 32'd0);
        rst = 1'b0;

        foreach (directed[i]) run_one(directed[i]);

        // Second start mid-conversion with a new operand must be ignored.
        @(negedge clk);
        bif.start    = 1'b1;
        bif.bin_d_in = 15'd4321;
        @(negedge clk);
        bif.start = 1'b0;
        repeat (4) @(negedge clk);
        bif.start    = 1'b1;
        bif.bin_d_in = 15'd1111;
        @(negedge clk);
        bif.start = 1'b0;
        wait_idle();

        // Reset 8 cycles in, with start also high: abort, no done afterwards.
        @(negedge clk);
        bif.start    = 1'b1;
        bif.bin_d_in = 15'd5555;
        @(negedge clk);
        bif.start = 1'b0;
        repeat (7) @(negedge clk);
        rst       = 1'b1;
        bif.start = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        bif.start = 1'b0;
        repeat (25) @(negedge clk);

        // Start held high: back-to-back conversions on a changing operand.
        bif.start = 1'b1;
        repeat (80) begin
            bif.bin_d_in = 15'($urandom_range(0, 32767));
            @(negedge clk);
        end
        bif.start = 1'b0;
        wait_idle();

        repeat (30) begin
            run_one(int'($urandom_range(0, 32767)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end
endmodule
